// File: rtl/bool_eval_pkg.sv
// Shared types and constants for the boolean-function truth-table sequencer.
package bool_eval_pkg;

  localparam int VEC_COUNT = 8;
  localparam int IDX_W     = 3;

  // Reference truth tables: bit i is the function value at {A,B,C} = i.
  localparam logic [7:0] DEF_EXP_F1 = 8'hD5;
  localparam logic [7:0] DEF_EXP_F2 = 8'hA8;
  localparam logic [7:0] DEF_EXP_F3 = 8'hC3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Number of set bits in a truth table (used to count mismatches).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bool_eval_settle_timer.sv
// Loadable 4-bit up/down counter with a terminal-value flag; paces the
// settle dwell of each input vector.
module bool_eval_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  input  logic       up_i,
  input  logic [3:0] term_i,
  output logic       tc_o
);

  logic [3:0] cnt_q, cnt_d;

  // Load has priority over counting; counting direction follows up_i.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = up_i ? (cnt_q + 4'd1) : (cnt_q - 4'd1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal flag is decoded from the registered count only.
  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/bool_eval_sequencer.sv
// Sweeps {A,B,C} over all eight vectors, lets the external evaluator settle,
// captures F1/F2/F3 into truth tables and compares them against references.
//
// Handshake: start is a single-cycle request honoured only in IDLE (abort has
// priority); busy stays high from acceptance until the cycle done pulses, and
// done is a one-cycle pulse in which pass/mismatch_cnt are already valid.
module bool_eval_sequencer
  import bool_eval_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXP_F1        = DEF_EXP_F1,
  parameter logic [7:0] EXP_F2        = DEF_EXP_F2,
  parameter logic [7:0] EXP_F3        = DEF_EXP_F3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F1,
  input  logic       F2,
  input  logic       F3,
  output logic       busy,
  output logic       done,
  output logic [7:0] f1_tt,
  output logic [7:0] f2_tt,
  output logic [7:0] f3_tt,
  output logic [2:0] pass,
  output logic [4:0] mismatch_cnt,
  output logic [2:0] dbg_state_o
);

  localparam logic [3:0]       SETTLE_TERM = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(VEC_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [7:0]       f1_q, f1_d, f2_q, f2_d, f3_q, f3_d;
  logic [2:0]       pass_q, pass_d;
  logic [4:0]       mm_q, mm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmr_clr, tmr_inc, tmr_tc;

  bool_eval_settle_timer u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_clr),
    .load_val_i (4'd0),
    .en_i       (tmr_inc),
    .up_i       (1'b1),
    .term_i     (SETTLE_TERM),
    .tc_o       (tmr_tc)
  );

  // Next-state and datapath updates; every register holds unless a state acts.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    f3_d    = f3_q;
    pass_d  = pass_q;
    mm_d    = mm_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_WAIT;
          index_d = '0;
          f1_d    = 8'h00;
          f2_d    = 8'h00;
          f3_d    = 8'h00;
          pass_d  = 3'b000;
          mm_d    = 5'd0;
          busy_d  = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_tc) begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          f1_d[index_q] = F1;
          f2_d[index_q] = F2;
          f3_d[index_q] = F3;
          if (index_q == LAST_IDX) begin
            index_d = '0;
            state_d = ST_CHECK;
          end else begin
            index_d = index_q + IDX_ONE;
            tmr_clr = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          pass_d  = {(f3_q == EXP_F3), (f2_q == EXP_F2), (f1_q == EXP_F1)};
          mm_d    = 5'(popcount8(f1_q ^ EXP_F1)) +
                    5'(popcount8(f2_q ^ EXP_F2)) +
                    5'(popcount8(f3_q ^ EXP_F3));
          // busy falls and done rises on the same edge that enters DONE.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards all sweep progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      f1_q    <= 8'h00;
      f2_q    <= 8'h00;
      f3_q    <= 8'h00;
      pass_q  <= 3'b000;
      mm_q    <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      f3_q    <= f3_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A            = index_q[2];
  assign B            = index_q[1];
  assign C            = index_q[0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign f1_tt        = f1_q;
  assign f2_tt        = f2_q;
  assign f3_tt        = f3_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mm_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bool_eval_sequencer.sv
// Bench for bool_eval_sequencer: two instances (default settle time and
// settle time 1), each driving a behavioural evaluator with injectable faults.
module tb_bool_eval_sequencer;

  localparam logic [7:0] TB_EXP_F1 = 8'hD5;
  localparam logic [7:0] TB_EXP_F2 = 8'hA8;
  localparam logic [7:0] TB_EXP_F3 = 8'hC3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 0 (default settle) ----------------
  logic       start0, abort0, a0, b0, c0, f1_0, f2_0, f3_0, busy0, done0;
  logic [7:0] f1tt0, f2tt0, f3tt0;
  logic [2:0] pass0, st0;
  logic [4:0] mm0;
  logic [7:0] flip_a [3];

  bool_eval_sequencer u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .A(a0), .B(b0), .C(c0), .F1(f1_0), .F2(f2_0), .F3(f3_0),
    .busy(busy0), .done(done0), .f1_tt(f1tt0), .f2_tt(f2tt0), .f3_tt(f3tt0),
    .pass(pass0), .mismatch_cnt(mm0), .dbg_state_o(st0)
  );

  // Evaluator: correct function value, optionally corrupted per vector.
  assign f1_0 = TB_EXP_F1[{a0, b0, c0}] ^ flip_a[0][{a0, b0, c0}];
  assign f2_0 = TB_EXP_F2[{a0, b0, c0}] ^ flip_a[1][{a0, b0, c0}];
  assign f3_0 = TB_EXP_F3[{a0, b0, c0}] ^ flip_a[2][{a0, b0, c0}];

  // ---------------- DUT 1 (settle = 1) ----------------
  logic       start1, abort1, a1, b1, c1, f1_1, f2_1, f3_1, busy1, done1;
  logic [7:0] f1tt1, f2tt1, f3tt1;
  logic [2:0] pass1, st1;
  logic [4:0] mm1;
  logic [7:0] flip_b [3];

  bool_eval_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .A(a1), .B(b1), .C(c1), .F1(f1_1), .F2(f2_1), .F3(f3_1),
    .busy(busy1), .done(done1), .f1_tt(f1tt1), .f2_tt(f2tt1), .f3_tt(f3tt1),
    .pass(pass1), .mismatch_cnt(mm1), .dbg_state_o(st1)
  );

  assign f1_1 = TB_EXP_F1[{a1, b1, c1}] ^ flip_b[0][{a1, b1, c1}];
  assign f2_1 = TB_EXP_F2[{a1, b1, c1}] ^ flip_b[1][{a1, b1, c1}];
  assign f3_1 = TB_EXP_F3[{a1, b1, c1}] ^ flip_b[2][{a1, b1, c1}];

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q0[$];
  logic [39:0] exp_q1[$];
  logic [39:0] e0, e1;
  int          start_cyc0, start_cyc1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Reference model: record = {done cycle, f1_tt, f2_tt, f3_tt, pass, mismatches}.
  function automatic logic [39:0] make_exp(input int settle, input logic [7:0] x1,
                                           input logic [7:0] x2, input logic [7:0] x3);
    logic [7:0] t1, t2, t3, cy;
    logic [2:0] p;
    logic [4:0] m;
    t1 = TB_EXP_F1 ^ x1;
    t2 = TB_EXP_F2 ^ x2;
    t3 = TB_EXP_F3 ^ x3;
    p  = {(t3 == TB_EXP_F3), (t2 == TB_EXP_F2), (t1 == TB_EXP_F1)};
    m  = 5'($countones(x1) + $countones(x2) + $countones(x3));
    cy = 8'(8 * (settle + 1) + 2);
    return {cy, t1, t2, t3, p, m};
  endfunction

  // Monitor for DUT 0: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (exp_q0.size() == 0) begin
        check("dut0_unexpected_done", 64'd1, 64'd0);
      end else begin
        e0 = exp_q0.pop_front();
        check("dut0_done_cycle", 64'(cyc - start_cyc0 + 1), 64'(e0[39:32]));
        check("dut0_f1_tt", 64'(f1tt0), 64'(e0[31:24]));
        check("dut0_f2_tt", 64'(f2tt0), 64'(e0[23:16]));
        check("dut0_f3_tt", 64'(f3tt0), 64'(e0[15:8]));
        check("dut0_pass", 64'(pass0), 64'(e0[7:5]));
        check("dut0_mismatch_cnt", 64'(mm0), 64'(e0[4:0]));
        check("dut0_busy_low_at_done", 64'(busy0), 64'd0);
      end
    end
  end

  // Monitor for DUT 1.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (exp_q1.size() == 0) begin
        check("dut1_unexpected_done", 64'd1, 64'd0);
      end else begin
        e1 = exp_q1.pop_front();
        check("dut1_done_cycle", 64'(cyc - start_cyc1 + 1), 64'(e1[39:32]));
        check("dut1_f1_tt", 64'(f1tt1), 64'(e1[31:24]));
        check("dut1_f2_tt", 64'(f2tt1), 64'(e1[23:16]));
        check("dut1_f3_tt", 64'(f3tt1), 64'(e1[15:8]));
        check("dut1_pass", 64'(pass1), 64'(e1[7:5]));
        check("dut1_mismatch_cnt", 64'(mm1), 64'(e1[4:0]));
        check("dut1_busy_low_at_done", 64'(busy1), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues a one-cycle start; when expect_done is set the model result is queued.
  task automatic sweep(input int d, input bit expect_done,
                       input logic [7:0] x1, input logic [7:0] x2, input logic [7:0] x3);
    if (d == 0) begin
      flip_a[0] = x1; flip_a[1] = x2; flip_a[2] = x3;
      if (expect_done) exp_q0.push_back(make_exp(2, x1, x2, x3));
      start0 = 1'b1;
      start_cyc0 = cyc + 1;
      @(negedge clk);
      start0 = 1'b0;
    end else begin
      flip_b[0] = x1; flip_b[1] = x2; flip_b[2] = x3;
      if (expect_done) exp_q1.push_back(make_exp(1, x1, x2, x3));
      start1 = 1'b1;
      start_cyc1 = cyc + 1;
      @(negedge clk);
      start1 = 1'b0;
    end
  endtask

  task automatic wait_done(input int d, input int budget);
    int n;
    n = 0;
    while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (d == 0) begin
      check("dut0_sweep_completes", 64'(exp_q0.size()), 64'd0);
      exp_q0.delete();
    end else begin
      check("dut1_sweep_completes", 64'(exp_q1.size()), 64'd0);
      exp_q1.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_flip();
    return ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, bc, c;
    logic [7:0] r1, r2, r3;
    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flip_a[i] = 8'h00;
      flip_b[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset_dut0_outputs", 64'({a0, b0, c0, busy0, done0, f1tt0, f2tt0, f3tt0, pass0, mm0}), 64'd0);
    check("reset_dut1_outputs", 64'({a1, b1, c1, busy1, done1, f1tt1, f2tt1, f3tt1, pass1, mm1}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fault-free sweep, then F2 stuck at 0.
    sweep(0, 1'b1, 8'h00, 8'h00, 8'h00);
    wait_done(0, 200);
    sweep(0, 1'b1, 8'h00, TB_EXP_F2, 8'h00);
    wait_done(0, 200);

    // Randomized fault patterns and idle gaps.
    for (int i = 0; i < 8; i++) begin
      r1 = rand_flip(); r2 = rand_flip(); r3 = rand_flip();
      repeat ($urandom_range(0, 4)) @(negedge clk);
      sweep(0, 1'b1, r1, r2, r3);
      wait_done(0, 200);
    end

    // Abort during the settle wait of vector 4.
    sweep(0, 1'b0, 8'h00, 8'h00, 8'h00);
    n = 0;
    while ({a0, b0, c0} != 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_index4", 64'({a0, b0, c0}), 64'd4);
    check("abort_in_wait_busy", 64'(busy0), 64'd1);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("abort_busy_drops", 64'(busy0), 64'd0);
    check("abort_f1_partial", 64'(f1tt0), 64'(TB_EXP_F1 & 8'h0F));
    check("abort_f2_partial", 64'(f2tt0), 64'(TB_EXP_F2 & 8'h0F));
    check("abort_f3_partial", 64'(f3tt0), 64'(TB_EXP_F3 & 8'h0F));
    check("abort_pass_partial", 64'(pass0), 64'd0);
    repeat (40) @(negedge clk);
    check("abort_abc_held", 64'({a0, b0, c0}), 64'd4);
    check("abort_stays_idle", 64'(busy0), 64'd0);
    sweep(0, 1'b1, 8'h00, 8'h00, 8'h00);
    wait_done(0, 200);

    // Start re-pulsed in cycles 5 and 20 of a running sweep.
    sweep(0, 1'b1, 8'h00, 8'h00, 8'h00);
    n = 0;
    while (exp_q0.size() != 0 && n < 200) begin
      c = cyc - start_cyc0 + 1;
      start0 = (c == 5 || c == 20);
      @(negedge clk);
      n++;
    end
    start0 = 1'b0;
    check("repulse_sweep_completes", 64'(exp_q0.size()), 64'd0);
    exp_q0.delete();
    repeat (30) @(negedge clk);
    check("repulse_no_restart", 64'(busy0), 64'd0);

    // Asynchronous reset in cycle 10 of a sweep.
    sweep(0, 1'b0, 8'h00, 8'h00, 8'h00);
    n = 0;
    while ((cyc - start_cyc0 + 1) != 10 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reset_midsweep_busy_before", 64'(busy0), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_async_clears", 64'({a0, b0, c0, busy0, done0, f1tt0, f2tt0, f3tt0, pass0, mm0}), 64'd0);
    check("reset_state_idle", 64'(st0), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy0) bc++;
    end
    check("reset_no_restart_busy_cycles", 64'(bc), 64'd0);

    // Settle time 1: abort wins over start, then a normal sweep.
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    check("dut1_abort_wins_busy", 64'(busy1), 64'd0);
    repeat (25) @(negedge clk);
    check("dut1_abort_wins_idle", 64'(busy1), 64'd0);
    sweep(1, 1'b1, 8'h00, 8'h00, 8'h00);
    wait_done(1, 200);
    for (int i = 0; i < 3; i++) begin
      r1 = rand_flip(); r2 = rand_flip(); r3 = rand_flip();
      sweep(1, 1'b1, r1, r2, r3);
      wait_done(1, 200);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
